// File: rtl/gray_pkg.sv
// gray_pkg -- constants shared by the Gray-code counter family.
//   GRAY_WIDTH_MIN / GRAY_WIDTH_MAX : legal range for the WIDTH parameter
//   DIR_UP / DIR_DN                 : encoding of the up_dn input
package gray_pkg;
    localparam int   GRAY_WIDTH_MIN = 2;
    localparam int   GRAY_WIDTH_MAX = 16;
    localparam logic DIR_UP         = 1'b1;
    localparam logic DIR_DN         = 1'b0;
endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if -- control and status bundle of gray_counter.
//   en, up_dn, load, load_val : control from the master
//   G, tc, at_max, at_min     : count status from the counter (slave)
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] G;
    logic             tc;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, up_dn, load, load_val,
        input  G, tc, at_max, at_min
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output G, tc, at_max, at_min
    );
endinterface

// File: rtl/bintogray.sv
// bintogray -- combinational binary-to-Gray encoder.
//   b : binary input (WIDTH bits)
//   g : Gray-coded output, g = b ^ (b >> 1)
module bintogray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);
    assign g = b ^ (b >> 1);
endmodule

// File: rtl/gray_counter.sv
// gray_counter -- Gray-code up/down counter with parallel load,
// terminal-count pulse and optional saturation at the bounds.
//   clk    : rising-edge clock
//   rst_n  : asynchronous, active-low reset
//   cif    : slave side of gray_counter_if
//            en / up_dn / load / load_val in, G / tc / at_max / at_min out
// A binary count is kept internally; the Gray register is loaded from the
// encoded next-count on the same edge, so G is always a flop output.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_counter_if.slave  cif
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    generate
        if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_width_chk
            $error("gray_counter: WIDTH out of range");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             tc_q, tc_d;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (cif.load) begin
            cnt_d = cif.load_val;
        end else if (cif.en && cif.up_dn == DIR_UP) begin
            if (cnt_q == CNT_MAX) begin
                tc_d  = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (cif.en && cif.up_dn == DIR_DN) begin
            if (cnt_q == '0) begin
                tc_d  = 1'b1;
                cnt_d = SATURATE ? cnt_q : CNT_MAX;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Encode the next count so G lands in step with cnt on the same edge.
    bintogray #(.WIDTH(WIDTH)) u_bintogray (
        .b (cnt_d),
        .g (g_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            g_q   <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            g_q   <= g_d;
            tc_q  <= tc_d;
        end
    end

    assign cif.G      = g_q;
    assign cif.tc     = tc_q;
    assign cif.at_max = (cnt_q == CNT_MAX);
    assign cif.at_min = (cnt_q == '0);
endmodule
